// File: rtl/ifu_prefetch.sv
// Sequential instruction prefetcher with DEPTH-entry in-order buffer and redirect flush.
// Optional IFU_PERF_CNT_EN adds saturating fetch/stall/drop counters.
module ifu_prefetch #(
  parameter int XLEN  = 64,
  parameter int ILEN  = 32,
  parameter int MEM_W = 64,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [XLEN-1:0]  req_addr,
  input  logic             resp_valid,
  input  logic [MEM_W-1:0] resp_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [ILEN-1:0]  out_inst
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [XLEN-1:0]  perf_fetch,
  output logic [XLEN-1:0]  perf_stall,
  output logic [XLEN-1:0]  perf_drop
`endif
);

  localparam int PW    = $clog2(DEPTH);
  localparam int NSLOT = MEM_W / ILEN;
  localparam int LO    = $clog2(ILEN / 8);
  localparam int SW    = (NSLOT > 1) ? $clog2(NSLOT) : 1;

  typedef logic [PW:0] ptr_t;

  logic [XLEN-1:0] fpc;
  ptr_t            alloc;
  ptr_t            fill;
  ptr_t            head;
  ptr_t            occ;
  ptr_t            drop_cnt;
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [ILEN-1:0] inst_mem [DEPTH];
  logic [DEPTH-1:0] filled;

  logic [PW-1:0] ai;
  logic [PW-1:0] fi;
  logic [PW-1:0] hi;
  logic          req_fire;
  logic          drop_resp;
  logic          fill_fire;
  logic          out_fire;
  logic [ILEN-1:0] slice;

  assign ai  = alloc[PW-1:0];
  assign fi  = fill[PW-1:0];
  assign hi  = head[PW-1:0];
  assign occ = alloc - head;

  assign req_valid = !rst && !redirect_valid && (occ < ptr_t'(DEPTH));
  assign req_addr  = fpc;
  assign req_fire  = req_valid && req_ready;

  // Responses during a redirect belong to flushed requests.
  assign drop_resp = resp_valid && (redirect_valid || drop_cnt != '0);
  assign fill_fire = resp_valid && !drop_resp;

  assign out_valid = !rst && filled[hi];
  assign out_fire  = out_valid && out_ready;
  assign out_pc    = pc_mem[hi];
  assign out_inst  = inst_mem[hi];

  generate
    if (NSLOT > 1) begin : g_sel
      logic [NSLOT-1:0][ILEN-1:0] words;
      logic [SW-1:0]              sel;
      assign words = resp_data;
      assign sel   = pc_mem[fi][LO +: SW];
      assign slice = words[sel];
    end else begin : g_one
      assign slice = resp_data[ILEN-1:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc      <= RESET_PC;
      alloc    <= '0;
      fill     <= '0;
      head     <= '0;
      drop_cnt <= '0;
      filled   <= '0;
    end else if (redirect_valid) begin
      fpc      <= redirect_pc;
      alloc    <= '0;
      fill     <= '0;
      head     <= '0;
      filled   <= '0;
      drop_cnt <= drop_cnt + (alloc - fill)
                - {{PW{1'b0}}, resp_valid};
    end else begin
      if (req_fire) begin
        fpc   <= fpc + XLEN'(ILEN / 8);
        alloc <= alloc + 1'b1;
      end
      if (drop_resp) drop_cnt <= drop_cnt - 1'b1;
      if (fill_fire) fill <= fill + 1'b1;
      if (out_fire) head <= head + 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        if (req_fire && ai == PW'(i)) filled[i] <= 1'b0;
        if (out_fire && hi == PW'(i)) filled[i] <= 1'b0;
        if (fill_fire && fi == PW'(i)) filled[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) pc_mem[ai] <= fpc;
    if (fill_fire) inst_mem[fi] <= slice;
  end

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch <= '0;
      perf_stall <= '0;
      perf_drop  <= '0;
    end else begin
      if (out_fire && !(&perf_fetch))
        perf_fetch <= perf_fetch + 1'b1;
      if (out_ready && !out_valid && !(&perf_stall))
        perf_stall <= perf_stall + 1'b1;
      if (drop_resp && !(&perf_drop))
        perf_drop <= perf_drop + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// Scoreboard bench for ifu_prefetch: latency-programmable memory model,
// expected (pc, inst) queue filled on request and checked on output.
module tb_ifu_prefetch;

  localparam logic [63:0] RPC = 64'h8000_0000;

  logic        clk = 0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
`ifdef IFU_PERF_CNT_EN
  logic [63:0] perf_fetch;
  logic [63:0] perf_stall;
  logic [63:0] perf_drop;
`endif

  ifu_prefetch dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst)
`ifdef IFU_PERF_CNT_EN
    , .perf_fetch(perf_fetch), .perf_stall(perf_stall),
    .perf_drop(perf_drop)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] pc; logic [31:0] inst; } exp_t;
  typedef struct { logic [63:0] addr; int due; } mreq_t;

  exp_t  exp_q[$];
  exp_t  got_q[$];
  mreq_t mem_q[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    lat = 1;
  int    nreq = 0;
  int    nout = 0;
  bit    fixed_mode = 0;
  logic [63:0] model_pc = RPC;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (fixed_mode) return a[2] ? 32'hAAAA_AAAA : 32'hBBBB_BBBB;
    return {a[17:2], ~a[17:2]};
  endfunction

  // Monitor, scoreboard and memory model
  initial begin
    exp_t e;
    logic [63:0] base;
    resp_valid = 0;
    resp_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        mem_q.delete();
        model_pc = RPC;
      end else begin
        if (out_valid && out_ready) begin
          nout++;
          got_q.push_back('{out_pc, out_inst});
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected out_pc=%h out_inst=%h required=none",
                     out_pc, out_inst);
          end else begin
            e = exp_q.pop_front();
            if (out_pc !== e.pc || out_inst !== e.inst) begin
              bad++;
              $display("FAIL sb_out got pc=%h inst=%h required pc=%h inst=%h",
                       out_pc, out_inst, e.pc, e.inst);
            end
          end
        end
        if (redirect_valid) begin
          exp_q.delete();
          model_pc = redirect_pc;
        end
        if (req_valid && req_ready) begin
          total++;
          if (req_addr !== model_pc) begin
            bad++;
            $display("FAIL req_addr got=%h required=%h", req_addr, model_pc);
          end
          exp_q.push_back('{model_pc, mem_word(model_pc)});
          mem_q.push_back('{model_pc, cyc + lat});
          model_pc += 64'd4;
          nreq++;
        end
        if (resp_valid && mem_q.size() > 0) void'(mem_q.pop_front());
      end
      @(posedge clk);
      #1;
      cyc++;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        resp_valid = 1;
        base = {mem_q[0].addr[63:3], 3'b000};
        resp_data = {mem_word(base + 64'd4), mem_word(base)};
      end else begin
        resp_valid = 0;
      end
    end
  end

  always @(negedge clk)
    if (!rst && redirect_valid)
      assert (redirect_pc[1:0] == 2'b00)
      else $error("misaligned redirect_pc %h", redirect_pc);

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1;
    redirect_valid = 0;
    redirect_pc = '0;
    req_ready = 0;
    out_ready = 0;
    fixed_mode = 0;
    repeat (2) step();
    rst = 0;
    got_q.delete();
  endtask

  task automatic wait_got(input int k, output bit ok);
    int n = 0;
    while (got_q.size() < k && n < 60) begin
      step();
      n++;
    end
    ok = (got_q.size() >= k);
  endtask

  task automatic drain();
    int n = 0;
    req_ready = 0;
    out_ready = 1;
    while ((exp_q.size() != 0 || mem_q.size() != 0) && n < 100) begin
      step();
      n++;
    end
    total++;
    if (n >= 100) begin
      bad++;
      $display("FAIL drain_timeout exp=%0d mem=%0d required=0",
               exp_q.size(), mem_q.size());
    end
  endtask

  task automatic test_reset();
    lat = 1;
    rst = 1;
    redirect_valid = 0;
    redirect_pc = '0;
    req_ready = 1;
    out_ready = 1;
    mid();
    total++;
    if (req_valid !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_outs req_valid=%b out_valid=%b required 0 0",
               req_valid, out_valid);
    end
    step();
    req_ready = 0;
    rst = 0;
    mid();
    total++;
    if (req_addr !== RPC || req_valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_pc req_addr=%h req_valid=%b required %h 1",
               req_addr, req_valid, RPC);
    end
    total++;
    if (int'(dut.drop_cnt) !== 0) begin
      bad++;
      $display("FAIL reset_drop got=%0d required=0", dut.drop_cnt);
    end
    step();
  endtask

  task automatic test_stream();
    int n0;
    lat = 1;
    do_reset();
    req_ready = 1;
    out_ready = 1;
    step();
    mid();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL stream_lat1 out_valid=%b required=0", out_valid);
    end
    step();
    mid();
    total++;
    if (out_valid !== 1'b1 || out_pc !== RPC) begin
      bad++;
      $display("FAIL stream_lat2 out_valid=%b out_pc=%h required 1 %h",
               out_valid, out_pc, RPC);
    end
    step();
    repeat (6) step();
    n0 = nout;
    repeat (10) step();
    total++;
    if (nout - n0 != 10) begin
      bad++;
      $display("FAIL stream_rate got=%0d required=10", nout - n0);
    end
    drain();
  endtask

  task automatic test_full();
    int n0;
    lat = 1;
    do_reset();
    req_ready = 1;
    out_ready = 0;
    n0 = nreq;
    repeat (10) step();
    total++;
    if (nreq - n0 != 4) begin
      bad++;
      $display("FAIL full_count got=%0d required=4", nreq - n0);
    end
    mid();
    total++;
    if (req_valid !== 1'b0 || req_addr !== RPC + 64'h10) begin
      bad++;
      $display("FAIL full_gate req_valid=%b req_addr=%h required 0 %h",
               req_valid, req_addr, RPC + 64'h10);
    end
    total++;
    if (out_valid !== 1'b1 || out_pc !== RPC) begin
      bad++;
      $display("FAIL full_head out_valid=%b out_pc=%h required 1 %h",
               out_valid, out_pc, RPC);
    end
    step();
    out_ready = 1;
    got_q.delete();
    n0 = nout;
    repeat (4) step();
    total++;
    if (nout - n0 != 4 || got_q.size() < 4) begin
      bad++;
      $display("FAIL full_drain got=%0d required=4", nout - n0);
    end else if (got_q[3].pc !== RPC + 64'hC) begin
      bad++;
      $display("FAIL full_order got=%h required=%h", got_q[3].pc, RPC + 64'hC);
    end
    drain();
  endtask

  task automatic test_slice();
    bit ok;
    lat = 1;
    do_reset();
    fixed_mode = 1;
    redirect_valid = 1;
    redirect_pc = RPC + 64'h4;
    req_ready = 1;
    out_ready = 1;
    step();
    redirect_valid = 0;
    step();
    step();
    req_ready = 0;
    wait_got(2, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL slice_timeout got=%0d required=2", got_q.size());
    end else begin
      if (got_q[0].pc !== RPC + 64'h4 || got_q[0].inst !== 32'hAAAA_AAAA) begin
        bad++;
        $display("FAIL slice_hi pc=%h inst=%h required %h AAAAAAAA",
                 got_q[0].pc, got_q[0].inst, RPC + 64'h4);
      end
      total++;
      if (got_q[1].pc !== RPC + 64'h8 || got_q[1].inst !== 32'hBBBB_BBBB) begin
        bad++;
        $display("FAIL slice_lo pc=%h inst=%h required %h BBBBBBBB",
                 got_q[1].pc, got_q[1].inst, RPC + 64'h8);
      end
    end
    drain();
    fixed_mode = 0;
  endtask

  task automatic test_redirect_drop();
    int n0;
    int exp_drop;
    bit ok;
    logic [63:0] tgt = 64'h8000_1000;
`ifdef IFU_PERF_CNT_EN
    logic [63:0] p0;
`endif
    lat = 3;
    do_reset();
`ifdef IFU_PERF_CNT_EN
    p0 = perf_drop;
`endif
    req_ready = 1;
    out_ready = 1;
    n0 = nreq;
    while (nreq - n0 < 3 && cyc < 100000) step();
    exp_drop = mem_q.size() - (resp_valid ? 1 : 0);
    redirect_valid = 1;
    redirect_pc = tgt;
    mid();
    total++;
    if (req_valid !== 1'b0) begin
      bad++;
      $display("FAIL drop_reqgate req_valid=%b required=0", req_valid);
    end
    step();
    redirect_valid = 0;
    got_q.delete();
    total++;
    if (int'(dut.drop_cnt) !== exp_drop) begin
      bad++;
      $display("FAIL drop_cnt got=%0d required=%0d", dut.drop_cnt, exp_drop);
    end
    wait_got(1, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL drop_timeout got=0 required=1");
    end else if (got_q[0].pc !== tgt || got_q[0].inst !== mem_word(tgt)) begin
      bad++;
      $display("FAIL drop_first pc=%h inst=%h required %h %h",
               got_q[0].pc, got_q[0].inst, tgt, mem_word(tgt));
    end
    drain();
`ifdef IFU_PERF_CNT_EN
    total++;
    if (perf_drop - p0 !== 64'd3) begin
      bad++;
      $display("FAIL perf_drop got=%0d required=3", perf_drop - p0);
    end
`endif
  endtask

  task automatic test_redirect_combo();
    int n0;
    int exp_drop;
    bit ok;
    logic [63:0] tgt = 64'h8000_2000;
    lat = 2;
    do_reset();
    req_ready = 1;
    out_ready = 1;
    repeat (6) step();
    total++;
    if (resp_valid !== 1'b1 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL combo_setup resp_valid=%b out_valid=%b required 1 1",
               resp_valid, out_valid);
    end
    exp_drop = mem_q.size() - (resp_valid ? 1 : 0);
    redirect_valid = 1;
    redirect_pc = tgt;
    n0 = nout;
    step();
    redirect_valid = 0;
    got_q.delete();
    total++;
    if (nout - n0 != 1) begin
      bad++;
      $display("FAIL combo_out got=%0d required=1", nout - n0);
    end
    total++;
    if (int'(dut.drop_cnt) !== exp_drop) begin
      bad++;
      $display("FAIL combo_drop got=%0d required=%0d", dut.drop_cnt, exp_drop);
    end
    wait_got(1, ok);
    total++;
    if (!ok || got_q[0].pc !== tgt) begin
      bad++;
      $display("FAIL combo_first ok=%b required pc=%h", ok, tgt);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [63:0] tgt = 64'h8000_3000;
    lat = 3;
    do_reset();
    req_ready = 1;
    out_ready = 1;
    repeat (5) step();
    redirect_valid = 1;
    redirect_pc = 64'h8000_2800;
    step();
    redirect_pc = tgt;
    step();
    redirect_valid = 0;
    got_q.delete();
    wait_got(1, ok);
    total++;
    if (!ok || got_q[0].pc !== tgt || got_q[0].inst !== mem_word(tgt)) begin
      bad++;
      $display("FAIL b2b_first ok=%b required pc=%h", ok, tgt);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    lat = 2;
    do_reset();
    req_ready = 1;
    out_ready = 1;
    repeat (5) step();
    rst = 1;
    mid();
    total++;
    if (req_valid !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_comb req_valid=%b out_valid=%b required 0 0",
               req_valid, out_valid);
    end
    step();
    rst = 0;
    mid();
    total++;
    if (req_addr !== RPC || req_valid !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_after req_addr=%h req_valid=%b out_valid=%b required %h 1 0",
               req_addr, req_valid, out_valid, RPC);
    end
    step();
    drain();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    redirect_valid = 0;
    redirect_pc = '0;
    req_ready = 0;
    out_ready = 0;
    repeat (2) step();
    test_reset();
    test_stream();
    test_full();
    test_slice();
    test_redirect_drop();
    test_redirect_combo();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
